// File: rtl/wr_arria10_rx_align_ctrl.sv
// wr_arria10_rx_align_ctrl
//
// Receive-side word alignment controller for an Arria 10 PHY lane. It issues
// a pattern-align pulse and waits for the word aligner to synchronise. Only an
// even bitslip boundary gives deterministic latency, so the boundary is
// checked. The link must then stay error free for a qualification window
// before rx_ready_o is raised. Any failure resets the PHY digital receive
// path and starts a new attempt; the attempts are counted.
//
// Ports
//   clk_i                    PHY rx_clkout; every register runs on it
//   rst_i                    synchronous active-high reset
//   rx_is_lockedtodata_i     CDR locked to data
//   rx_syncstatus_i          word aligner synchronised
//   rx_errdetect_i           8b/10b code error
//   rx_disperr_i             disparity error
//   rx_bitslipboundarysel_i  aligner bitslip boundary (5 bits)
//   rx_data_i / rx_datak_i   decoded data byte and K flag
//   rx_patternalign_o        to PHY rx_std_wa_patternalign
//   rx_digitalreset_req_o    request for PHY rx_digitalreset
//   rx_data_o / rx_k_o       registered data, forced to zero unless ready
//   rx_enc_err_o             registered code/disparity error, zero unless ready
//   rx_bitslide_o            boundary latched during the boundary check
//   rx_ready_o               link aligned with deterministic latency
//   retry_count_o            saturating count of alignment retries

module wr_arria10_rx_align_ctrl #(
    parameter int unsigned g_lock_timeout  = 65535,
    parameter int unsigned g_stable_cycles = 1024,
    parameter int unsigned g_reset_cycles  = 32,
    parameter int unsigned g_align_cycles  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_is_lockedtodata_i,
    input  logic       rx_syncstatus_i,
    input  logic       rx_errdetect_i,
    input  logic       rx_disperr_i,
    input  logic [4:0] rx_bitslipboundarysel_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_datak_i,
    output logic       rx_patternalign_o,
    output logic       rx_digitalreset_req_o,
    output logic [7:0] rx_data_o,
    output logic       rx_k_o,
    output logic       rx_enc_err_o,
    output logic [4:0] rx_bitslide_o,
    output logic       rx_ready_o,
    output logic [7:0] retry_count_o
);

    // One timer is shared by every timed state, so it is sized for the
    // longest interval. It only has to reach (interval - 1).
    localparam int unsigned MaxLockStable = (g_lock_timeout > g_stable_cycles) ? g_lock_timeout : g_stable_cycles;
    localparam int unsigned MaxResetAlign = (g_reset_cycles > g_align_cycles) ? g_reset_cycles : g_align_cycles;
    localparam int unsigned MaxCycles     = (MaxLockStable > MaxResetAlign) ? MaxLockStable : MaxResetAlign;
    localparam int unsigned TimerW        = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [TimerW-1:0] AlignLast  = TimerW'(g_align_cycles - 1);
    localparam logic [TimerW-1:0] LockLast   = TimerW'(g_lock_timeout - 1);
    localparam logic [TimerW-1:0] StableLast = TimerW'(g_stable_cycles - 1);
    localparam logic [TimerW-1:0] ResetLast  = TimerW'(g_reset_cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        WAIT_SYNC,
        CHECK,
        STABLE,
        READY,
        RESET_RX
    } state_t;

    state_t            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [7:0]        retryCount_q;
    logic [4:0]        bitslide_q;
    logic [7:0]        data_q;
    logic              k_q;
    logic              encErr_q;
    logic              linkError;

    assign linkError = !rx_syncstatus_i || rx_errdetect_i || rx_disperr_i;

    // The timer restarts from zero on every state change, so each state
    // sees its own cycle count starting at 0 on its first cycle.
    assign timer_d = (state_d != state_q) ? '0 : timer_q + TimerW'(1);

    // State register, timer, retry counter and latched bitslip boundary.
    // A retry is counted on the edge that enters RESET_RX. The counter
    // saturates instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            retryCount_q <= '0;
            bitslide_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (state_d == RESET_RX && state_q != RESET_RX && retryCount_q != 8'hFF) begin
                retryCount_q <= retryCount_q + 8'd1;
            end
            if (state_q == CHECK) begin
                bitslide_q <= rx_bitslipboundarysel_i;
            end
        end
    end

    // The data path is registered every cycle. It is zeroed only at the
    // outputs, so the outputs fall together with rx_ready_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            k_q      <= 1'b0;
            encErr_q <= 1'b0;
        end else begin
            data_q   <= rx_data_i;
            k_q      <= rx_datak_i;
            encErr_q <= rx_errdetect_i || rx_disperr_i;
        end
    end

    // Next-state logic. In WAIT_SYNC, sync has priority over the timeout.
    // An odd bitslip boundary gives non-deterministic latency, so it is
    // retried. Losing CDR lock overrides everything except IDLE and
    // RESET_RX, which already handle an unlocked CDR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (rx_is_lockedtodata_i) state_d = ALIGN;
            ALIGN:     if (timer_q == AlignLast) state_d = WAIT_SYNC;
            WAIT_SYNC: begin
                if (rx_syncstatus_i) begin
                    state_d = CHECK;
                end else if (timer_q == LockLast) begin
                    state_d = RESET_RX;
                end
            end
            CHECK:     state_d = rx_bitslipboundarysel_i[0] ? RESET_RX : STABLE;
            STABLE: begin
                if (linkError) begin
                    state_d = RESET_RX;
                end else if (timer_q == StableLast) begin
                    state_d = READY;
                end
            end
            READY:     if (!rx_syncstatus_i) state_d = RESET_RX;
            RESET_RX:  if (timer_q == ResetLast) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (!rx_is_lockedtodata_i && state_q != IDLE && state_q != RESET_RX) begin
            state_d = RESET_RX;
        end
    end

    // Outputs are decoded from the registered state. Data and error
    // outputs are forced to zero outside READY.
    always_comb begin
        rx_patternalign_o     = (state_q == ALIGN);
        rx_digitalreset_req_o = (state_q == RESET_RX);
        rx_ready_o            = (state_q == READY);
        rx_data_o             = rx_ready_o ? data_q : 8'h00;
        rx_k_o                = rx_ready_o && k_q;
        rx_enc_err_o          = rx_ready_o && encErr_q;
        rx_bitslide_o         = bitslide_q;
        retry_count_o         = retryCount_q;
    end

endmodule

// File: tb/tb_wr_arria10_rx_align_ctrl.sv
// tb_wr_arria10_rx_align_ctrl
//
// Bench for the receive alignment controller. The lock timeout is shortened
// so that the retry counter can be driven into saturation in a short run.
// The other intervals keep their default values. Inputs change on the
// falling edge, and outputs are observed on the falling edge before the
// next inputs are applied.

module tb_wr_arria10_rx_align_ctrl;

    localparam int LockTimeout  = 40;
    localparam int StableCycles = 1024;
    localparam int ResetCycles  = 32;
    localparam int AlignCycles  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       syncStatus = 1'b0;
    logic       errDetect = 1'b0;
    logic       dispErr = 1'b0;
    logic [4:0] boundary = '0;
    logic [7:0] dataIn = '0;
    logic       kIn = 1'b0;

    logic       patternAlign;
    logic       resetReq;
    logic [7:0] dataOut;
    logic       kOut;
    logic       encErr;
    logic [4:0] bitslide;
    logic       ready;
    logic [7:0] retryCount;

    int assertCount = 0;
    int failCount   = 0;
    int expRetry    = 0;
    logic [9:0] sbQueue[$];

    wr_arria10_rx_align_ctrl #(
        .g_lock_timeout (LockTimeout),
        .g_stable_cycles(StableCycles),
        .g_reset_cycles (ResetCycles),
        .g_align_cycles (AlignCycles)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .rx_is_lockedtodata_i   (locked),
        .rx_syncstatus_i        (syncStatus),
        .rx_errdetect_i         (errDetect),
        .rx_disperr_i           (dispErr),
        .rx_bitslipboundarysel_i(boundary),
        .rx_data_i              (dataIn),
        .rx_datak_i             (kIn),
        .rx_patternalign_o      (patternAlign),
        .rx_digitalreset_req_o  (resetReq),
        .rx_data_o              (dataOut),
        .rx_k_o                 (kOut),
        .rx_enc_err_o           (encErr),
        .rx_bitslide_o          (bitslide),
        .rx_ready_o             (ready),
        .retry_count_o          (retryCount)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net: the run must always end, even if the DUT stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic l, input logic s, input logic e, input logic d, input logic [4:0] b);
        locked     = l;
        syncStatus = s;
        errDetect  = e;
        dispErr    = d;
        boundary   = b;
    endtask

    // Holds reset for two edges, then releases it on a falling edge.
    // No inputs have been sampled since the release when this returns.
    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        dataIn = '0;
        kIn    = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        expRetry = 0;
    endtask

    // Counts how many cycles rx_digitalreset_req_o stays high, starting
    // from a cycle in which it is already observed high.
    task automatic measureReset(output int n);
        n = 0;
        while (resetReq === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd7);
        dataIn = 8'hFF;
        kIn    = 1'b1;
        tick();
        tick();
        assertCount++; if (patternAlign !== 1'b0) begin failCount++; $display("[TB] FAIL reset_patternalign: got %0b expected 0", patternAlign); end
        assertCount++; if (resetReq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_digitalreset: got %0b expected 0", resetReq); end
        assertCount++; if (ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready: got %0b expected 0", ready); end
        assertCount++; if ({encErr, kOut, dataOut} !== 10'd0) begin failCount++; $display("[TB] FAIL reset_data: got %0h expected 0", {encErr, kOut, dataOut}); end
        assertCount++; if (bitslide !== 5'd0) begin failCount++; $display("[TB] FAIL reset_bitslide: got %0d expected 0", bitslide); end
        assertCount++; if (retryCount !== 8'd0) begin failCount++; $display("[TB] FAIL reset_retry: got %0d expected 0", retryCount); end
    endtask

    task automatic test_nominal();
        int hi;
        int first;
        int n;
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd4);
        hi = 0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (patternAlign === 1'b1) begin
                if (hi == 0) first = i;
                hi++;
            end else if (hi > 0) begin
                break;
            end
        end
        assertCount++; if (first != 1) begin failCount++; $display("[TB] FAIL align_start: got cycle %0d expected 1", first); end
        assertCount++; if (hi != AlignCycles) begin failCount++; $display("[TB] FAIL align_width: got %0d expected %0d", hi, AlignCycles); end
        tick();
        syncStatus = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        assertCount++; if (n != StableCycles + 2) begin failCount++; $display("[TB] FAIL ready_latency: got %0d expected %0d", n, StableCycles + 2); end
        assertCount++; if (bitslide !== 5'd4) begin failCount++; $display("[TB] FAIL nominal_bitslide: got %0d expected 4", bitslide); end
        assertCount++; if (retryCount !== 8'(expRetry)) begin failCount++; $display("[TB] FAIL nominal_retry: got %0d expected %0d", retryCount, expRetry); end
        assertCount++; if (resetReq !== 1'b0) begin failCount++; $display("[TB] FAIL nominal_digitalreset: got %0b expected 0", resetReq); end
    endtask

    task automatic test_datapath();
        logic [9:0] exp;
        for (int i = 0; i < 24; i++) begin
            dataIn    = 8'($urandom);
            kIn       = 1'($urandom);
            errDetect = (i % 7 == 3);
            dispErr   = (i % 5 == 2);
            sbQueue.push_back({errDetect | dispErr, kIn, dataIn});
            tick();
            if (sbQueue.size() > 0) begin
                exp = sbQueue.pop_front();
                assertCount++; if ({encErr, kOut, dataOut} !== exp) begin failCount++; $display("[TB] FAIL datapath_%0d: got %0h expected %0h", i, {encErr, kOut, dataOut}, exp); end
            end
            assertCount++; if (ready !== 1'b1) begin failCount++; $display("[TB] FAIL datapath_ready_%0d: got %0b expected 1", i, ready); end
        end
        errDetect = 1'b0;
        dispErr   = 1'b0;
    endtask

    task automatic test_ready_loss();
        int n;
        dataIn  = 8'hA5;
        dispErr = 1'b1;
        tick();
        assertCount++; if (encErr !== 1'b1) begin failCount++; $display("[TB] FAIL disperr_flag: got %0b expected 1", encErr); end
        assertCount++; if (ready !== 1'b1) begin failCount++; $display("[TB] FAIL disperr_ready: got %0b expected 1", ready); end
        dispErr = 1'b0;
        tick();
        assertCount++; if (encErr !== 1'b0) begin failCount++; $display("[TB] FAIL disperr_clear: got %0b expected 0", encErr); end
        assertCount++; if (dataOut !== 8'hA5) begin failCount++; $display("[TB] FAIL ready_data: got %0h expected a5", dataOut); end
        syncStatus = 1'b0;
        dataIn     = 8'h5A;
        tick();
        expRetry++;
        assertCount++; if (ready !== 1'b0) begin failCount++; $display("[TB] FAIL loss_ready: got %0b expected 0", ready); end
        assertCount++; if (dataOut !== 8'h00) begin failCount++; $display("[TB] FAIL loss_data: got %0h expected 0", dataOut); end
        assertCount++; if (resetReq !== 1'b1) begin failCount++; $display("[TB] FAIL loss_digitalreset: got %0b expected 1", resetReq); end
        assertCount++; if (retryCount !== 8'(expRetry)) begin failCount++; $display("[TB] FAIL loss_retry: got %0d expected %0d", retryCount, expRetry); end
        measureReset(n);
        assertCount++; if (n != ResetCycles) begin failCount++; $display("[TB] FAIL loss_reset_width: got %0d expected %0d", n, ResetCycles); end
        tick();
        assertCount++; if (patternAlign !== 1'b1) begin failCount++; $display("[TB] FAIL loss_realign: got %0b expected 1", patternAlign); end
    endtask

    task automatic test_odd_slip();
        int n;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd3);
        n = 0;
        while (resetReq !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        expRetry++;
        assertCount++; if (n != AlignCycles + 3) begin failCount++; $display("[TB] FAIL odd_reset_time: got %0d expected %0d", n, AlignCycles + 3); end
        assertCount++; if (retryCount !== 8'(expRetry)) begin failCount++; $display("[TB] FAIL odd_retry: got %0d expected %0d", retryCount, expRetry); end
        assertCount++; if (bitslide !== 5'd3) begin failCount++; $display("[TB] FAIL odd_bitslide: got %0d expected 3", bitslide); end
        measureReset(n);
        assertCount++; if (n != ResetCycles) begin failCount++; $display("[TB] FAIL odd_reset_width: got %0d expected %0d", n, ResetCycles); end
        tick();
        assertCount++; if (patternAlign !== 1'b1) begin failCount++; $display("[TB] FAIL odd_realign: got %0b expected 1", patternAlign); end
    endtask

    task automatic test_lock_loss();
        int n;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2);
        repeat (10) tick();
        locked = 1'b0;
        tick();
        expRetry++;
        assertCount++; if (resetReq !== 1'b1) begin failCount++; $display("[TB] FAIL lockloss_digitalreset: got %0b expected 1", resetReq); end
        assertCount++; if (retryCount !== 8'(expRetry)) begin failCount++; $display("[TB] FAIL lockloss_retry: got %0d expected %0d", retryCount, expRetry); end
        measureReset(n);
        assertCount++; if (n != ResetCycles) begin failCount++; $display("[TB] FAIL lockloss_reset_width: got %0d expected %0d", n, ResetCycles); end
        repeat (3) tick();
        assertCount++; if ({patternAlign, resetReq} !== 2'b00) begin failCount++; $display("[TB] FAIL lockloss_idle: got %0b expected 00", {patternAlign, resetReq}); end
    endtask

    task automatic test_timeout_tie();
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd6);
        repeat (AlignCycles + LockTimeout) tick();
        assertCount++; if ({patternAlign, resetReq} !== 2'b00) begin failCount++; $display("[TB] FAIL tie_waitsync: got %0b expected 00", {patternAlign, resetReq}); end
        syncStatus = 1'b1;
        tick();
        assertCount++; if (resetReq !== 1'b0) begin failCount++; $display("[TB] FAIL tie_check: got %0b expected 0", resetReq); end
        tick();
        assertCount++; if (resetReq !== 1'b0) begin failCount++; $display("[TB] FAIL tie_stable: got %0b expected 0", resetReq); end
        assertCount++; if (bitslide !== 5'd6) begin failCount++; $display("[TB] FAIL tie_bitslide: got %0d expected 6", bitslide); end
        assertCount++; if (retryCount !== 8'd0) begin failCount++; $display("[TB] FAIL tie_retry: got %0d expected 0", retryCount); end
    endtask

    task automatic test_stable_error();
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2);
        repeat (507) tick();
        assertCount++; if ({ready, resetReq} !== 2'b00) begin failCount++; $display("[TB] FAIL stable_midway: got %0b expected 00", {ready, resetReq}); end
        errDetect = 1'b1;
        tick();
        errDetect = 1'b0;
        expRetry++;
        assertCount++; if ({ready, resetReq} !== 2'b01) begin failCount++; $display("[TB] FAIL stable_error: got %0b expected 01", {ready, resetReq}); end
        assertCount++; if (retryCount !== 8'(expRetry)) begin failCount++; $display("[TB] FAIL stable_retry: got %0d expected %0d", retryCount, expRetry); end
        repeat (9) tick();
        assertCount++; if (resetReq !== 1'b1) begin failCount++; $display("[TB] FAIL stable_reset_hold: got %0b expected 1", resetReq); end
        rst = 1'b1;
        tick();
        expRetry = 0;
        assertCount++; if ({patternAlign, resetReq, ready, encErr, kOut} !== 5'd0) begin failCount++; $display("[TB] FAIL abort_flags: got %0b expected 0", {patternAlign, resetReq, ready, encErr, kOut}); end
        assertCount++; if ({retryCount, bitslide, dataOut} !== 21'd0) begin failCount++; $display("[TB] FAIL abort_values: got %0h expected 0", {retryCount, bitslide, dataOut}); end
        rst = 1'b0;
        tick();
        assertCount++; if (patternAlign !== 1'b1) begin failCount++; $display("[TB] FAIL abort_idle_to_align: got %0b expected 1", patternAlign); end
    endtask

    task automatic test_timeout();
        int n;
        int guard;
        int sat;
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        n = 0;
        while (resetReq !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        assertCount++; if (n != AlignCycles + LockTimeout + 1) begin failCount++; $display("[TB] FAIL timeout_time: got %0d expected %0d", n, AlignCycles + LockTimeout + 1); end
        assertCount++; if (retryCount !== 8'd1) begin failCount++; $display("[TB] FAIL timeout_retry_1: got %0d expected 1", retryCount); end
        for (int i = 2; i <= 300; i++) begin
            guard = 0;
            while (resetReq === 1'b1 && guard < 100) begin
                tick();
                guard++;
            end
            while (resetReq !== 1'b1 && guard < 300) begin
                tick();
                guard++;
            end
            sat = (i > 255) ? 255 : i;
            assertCount++; if (guard >= 300) begin failCount++; $display("[TB] FAIL timeout_wait_%0d: got no retry within %0d cycles expected one", i, guard); end
            assertCount++; if (retryCount !== 8'(sat)) begin failCount++; $display("[TB] FAIL timeout_retry_%0d: got %0d expected %0d", i, retryCount, sat); end
        end
    endtask

    initial begin
        $display("[TB] starting wr_arria10_rx_align_ctrl bench");
        test_reset();
        test_nominal();
        test_datapath();
        test_ready_loss();
        test_odd_slip();
        test_lock_loss();
        test_timeout_tie();
        test_stable_error();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/wr_arria10_rx_align_ctrl.md
WR_ARRIA10_RX_ALIGN_CTRL -- requirements
Module: wr_arria10_rx_align_ctrl

Interface
REQ-001 SHALL have parameter g_lock_timeout, default 65535, max cycles in WAIT_SYNC before retry.
REQ-002 SHALL have parameter g_stable_cycles, default 1024, error-free cycles required before ready.
REQ-003 SHALL have parameter g_reset_cycles, default 32, cycles rx_digitalreset_req_o is held.
REQ-004 SHALL have parameter g_align_cycles, default 4, width of rx_patternalign_o pulse.
REQ-005 clk_i  in  1  PHY rx_clkout domain; every register in the block is on this clock.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 rx_is_lockedtodata_i  in  1  CDR locked to data.
REQ-008 rx_syncstatus_i  in  1  word aligner synchronized.
REQ-009 rx_errdetect_i  in  1  8b/10b code error.
REQ-010 rx_disperr_i  in  1  disparity error.
REQ-011 rx_bitslipboundarysel_i  in  5  aligner bitslip boundary.
REQ-012 rx_data_i  in  8  decoded data; rx_datak_i  in  1  K flag.
REQ-013 rx_patternalign_o  out  1  to PHY rx_std_wa_patternalign.
REQ-014 rx_digitalreset_req_o  out  1  request to reset controller for PHY rx_digitalreset.
REQ-015 rx_data_o  out  8, rx_k_o  out  1  gated registered data.
REQ-016 rx_enc_err_o  out  1  registered code/disparity error.
REQ-017 rx_bitslide_o  out  5  latched boundary, valid while rx_ready_o.
REQ-018 rx_ready_o  out  1  link aligned with deterministic latency.
REQ-019 retry_count_o  out  8  saturating count of alignment retries.

Function
REQ-020 FSM states SHALL be IDLE, ALIGN, WAIT_SYNC, CHECK, STABLE, READY, RESET_RX.
REQ-021 IDLE: when rx_is_lockedtodata_i=1 -> ALIGN next cycle.
REQ-022 ALIGN: rx_patternalign_o=1 for exactly g_align_cycles cycles, then -> WAIT_SYNC.
REQ-023 WAIT_SYNC: rx_syncstatus_i=1 -> CHECK; timer reaching g_lock_timeout cycles -> RESET_RX.
REQ-024 CHECK (1 cycle): latch rx_bitslipboundarysel_i into rx_bitslide_o; bit0=0 -> STABLE; bit0=1 (odd slip, non-deterministic) -> RESET_RX.
REQ-025 STABLE: counter from 0; any cycle with syncstatus=0, errdetect=1 or disperr=1 -> RESET_RX; counter reaching g_stable_cycles-1 with no error -> READY.
REQ-026 READY: rx_ready_o=1; syncstatus=0 or lockedtodata=0 -> RESET_RX; errdetect/disperr SHALL NOT leave READY.
REQ-027 RESET_RX: rx_digitalreset_req_o=1 for exactly g_reset_cycles cycles, retry_count_o increments once on entry, saturating at 255, then -> IDLE.
REQ-028 rx_is_lockedtodata_i=0 in any state other than IDLE/RESET_RX SHALL force -> RESET_RX, priority over all other transitions.
REQ-029 Simultaneous timeout and syncstatus=1 in WAIT_SYNC SHALL take CHECK.
REQ-030 rx_data_o/rx_k_o SHALL be rx_data_i/rx_datak_i delayed 1 cycle when in READY, else 0x00/0.
REQ-031 rx_enc_err_o SHALL be (errdetect|disperr) delayed 1 cycle, gated to 0 outside READY.
REQ-032 rx_ready_o SHALL drop in the same cycle the FSM leaves READY (registered state decode, 1 cycle after causing input).
REQ-033 Timers SHALL be sized for their parameter and cleared on every state entry.

Reset
REQ-034 rst_i=1 on a clock edge SHALL put FSM in IDLE, all outputs 0, retry_count_o=0, rx_bitslide_o=0, all timers 0.
REQ-035 rst_i mid-sequence (incl. during RESET_RX) SHALL abort immediately; rx_digitalreset_req_o and rx_patternalign_o low on the next cycle.

Verification
REQ-036 locked=1, syncstatus=1 two cycles after ALIGN ends, boundary=4, no errors -> patternalign high 4 cycles, rx_ready_o=1 after 1024 STABLE cycles, rx_bitslide_o=4, retry_count_o=0.
REQ-037 boundary=3 at CHECK -> rx_digitalreset_req_o high 32 cycles, retry_count_o=1, new ALIGN pulse follows.
REQ-038 syncstatus held 0 -> RESET_RX after 65535 WAIT_SYNC cycles; repeat 300 times -> retry_count_o saturates at 255.
REQ-039 In READY, single disperr=1 -> rx_enc_err_o=1 for one cycle, rx_ready_o stays 1; then syncstatus=0 -> rx_ready_o=0, rx_data_o=0x00, RESET_RX.
REQ-040 errdetect=1 at STABLE cycle 500 -> RESET_RX, no ready; rst_i during RESET_RX cycle 10 -> all outputs 0 next cycle, FSM IDLE.
